// File: rtl/mem_access_pkg.sv
// Shared RV32I core definitions: writeback selects, load/store funct3 codes,
// memory-stage FSM encoding and the Writeback register bundle.
package cpu_defs;

  localparam logic [1:0] WB_ALU_SEL = 2'd0;
  localparam logic [1:0] WB_MEM_SEL = 2'd1;
  localparam logic [1:0] WB_PC4_SEL = 2'd2;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic [1:0]  wb_mux;
    logic [31:0] alu_out;
    logic [31:0] mem_data;
    logic [31:0] pc;
  } wb_regs_t;

  // funct3[1:0] encodes access width: 00 byte, 01 halfword, 10 word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/ready data-memory port between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ready
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/halfword from a 32-bit read word and sign- or
// zero-extends it according to the load funct3.
module load_align
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfwords come from aligned lanes only, so an odd offset truncates.
  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LBU:     data = {24'h000000, byte_sel};
      LHU:     data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: drives the data-memory port, stalls while an
// access is outstanding and registers results for Writeback.
// Optional feature: MEM_MISALIGN_TRAP_EN adds misaligned-access fault reporting.
module mem_access
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic        reg_write,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  wb_mux,
  input  logic [31:0] pc,
  output logic [31:0] forward_mem,
  output logic        stall,
  mem_access_if.master dmem,
  output logic [4:0]  rd_addr_out,
  output logic        reg_write_out,
  output logic [1:0]  wb_mux_out,
  output logic [31:0] alu_out_out,
  output logic [31:0] mem_data_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_fault,
`endif
  output logic [31:0] pc_out
);

  mem_state_e  state_q, state_d;
  wb_regs_t    wb_q, wb_d;
  logic [1:0]  off;
  logic        mem_op;
  logic        misaligned;
  logic        access;
  logic        req;
  logic [31:0] load_data;

  assign off         = alu_result[1:0];
  assign mem_op      = mem_write | (wb_mux == WB_MEM_SEL);
  assign forward_mem = alu_result;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mem_op & is_misaligned(funct3, off);
`else
  assign misaligned = 1'b0;
`endif

  assign access = mem_op & ~misaligned;

  // Request/stall are gated by reset so an abandoned access never lingers.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    if (!reset) begin
      case (state_q)
        MEM_IDLE: begin
          req = access;
          if (access && !dmem.ready) begin
            stall   = 1'b1;
            state_d = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          req = 1'b1;
          if (dmem.ready) begin
            state_d = MEM_IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = MEM_IDLE;
      endcase
    end
  end

  assign dmem.req  = req;
  assign dmem.we   = req & mem_write;
  assign dmem.addr = {alu_result[31:2], 2'b00};

  always_comb begin
    dmem.be    = 4'b1111;
    dmem.wdata = rs2_data;
    if (mem_write) begin
      case (funct3)
        SB: begin
          dmem.be    = 4'b0001 << off;
          dmem.wdata = {4{rs2_data[7:0]}};
        end
        SH: begin
          dmem.be    = 4'b0011 << off;
          dmem.wdata = {2{rs2_data[15:0]}};
        end
        SW: begin
          dmem.be    = 4'b1111;
          dmem.wdata = rs2_data;
        end
        default: begin
          dmem.be    = 4'b0000;
          dmem.wdata = rs2_data;
        end
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmem.rdata),
    .off    (off),
    .funct3 (funct3),
    .data   (load_data)
  );

  // A stalled cycle writes a bubble so Writeback never sees a half-done access.
  always_comb begin
    wb_d.rd_addr   = rd_addr;
    wb_d.reg_write = reg_write & ~misaligned;
    wb_d.wb_mux    = wb_mux;
    wb_d.alu_out   = alu_result;
    wb_d.mem_data  = load_data;
    wb_d.pc        = pc;
    if (stall) begin
      wb_d.reg_write = 1'b0;
      wb_d.wb_mux    = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_fault_q, misalign_fault_d;

  assign misalign_fault_d = misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_fault_q <= 1'b0;
    end else begin
      misalign_fault_q <= misalign_fault_d;
    end
  end

  assign misalign_fault = misalign_fault_q;
`endif

  assign rd_addr_out   = wb_q.rd_addr;
  assign reg_write_out = wb_q.reg_write;
  assign wb_mux_out    = wb_q.wb_mux;
  assign alu_out_out   = wb_q.alu_out;
  assign mem_data_out  = wb_q.mem_data;
  assign pc_out        = wb_q.pc;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: randomized instructions with a high-level
// reference model; honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_access;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result, rs2_data, pc;
  logic [4:0]  rd_addr;
  logic        reg_write, mem_write;
  logic [2:0]  funct3;
  logic [1:0]  wb_mux;
  logic [31:0] forward_mem;
  logic        stall;
  logic [4:0]  rd_addr_out;
  logic        reg_write_out;
  logic [1:0]  wb_mux_out;
  logic [31:0] alu_out_out, mem_data_out, pc_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  mem_access_if dmem_bus ();

  always #5 clk = ~clk;

  mem_access dut (
    .clk           (clk),
    .reset         (reset),
    .alu_result    (alu_result),
    .rs2_data      (rs2_data),
    .rd_addr       (rd_addr),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .funct3        (funct3),
    .wb_mux        (wb_mux),
    .pc            (pc),
    .forward_mem   (forward_mem),
    .stall         (stall),
    .dmem          (dmem_bus.master),
    .rd_addr_out   (rd_addr_out),
    .reg_write_out (reg_write_out),
    .wb_mux_out    (wb_mux_out),
    .alu_out_out   (alu_out_out),
    .mem_data_out  (mem_data_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_fault(misalign_fault),
`endif
    .pc_out        (pc_out)
  );

  typedef struct {
    logic [31:0] alu, rs2, pc, rdata;
    logic [4:0]  rd;
    logic        rw, mw;
    logic [2:0]  f3;
    logic [1:0]  wb;
    int          wait_cycles;
  } instr_t;

  typedef struct {
    logic [31:0] alu, pc, addr, wdata, mem_data;
    logic [4:0]  rd;
    logic        rw, is_load, req, we, fault;
    logic [1:0]  wb;
    logic [3:0]  be;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_accept = 1'b0;
  logic prev_bubble = 1'b0;
  int   stall_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: derived from access width, byte offset and arithmetic.
  function automatic exp_t model(input instr_t i);
    exp_t        e;
    int          off;
    int          nbytes;
    logic        is_store, is_load, misal;
    logic [31:0] lane, v;
    off      = int'(i.alu[1:0]);
    nbytes   = (i.f3[1:0] == 2'b00) ? 1 : (i.f3[1:0] == 2'b01) ? 2 : 4;
    is_store = i.mw;
    is_load  = (i.wb == WB_MEM_SEL);
    misal    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misal = (is_store || is_load) && ((nbytes == 2 && (off % 2) != 0) || (nbytes == 4 && off != 0));
`endif
    e.alu     = i.alu;
    e.pc      = i.pc;
    e.rd      = i.rd;
    e.wb      = i.wb;
    e.rw      = i.rw && !misal;
    e.is_load = is_load;
    e.fault   = misal;
    e.req     = (is_store || is_load) && !misal;
    e.stalls  = e.req ? i.wait_cycles : 0;
    e.we      = is_store;
    e.addr    = i.alu & 32'hFFFF_FFFC;
    e.be      = is_store ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
    e.wdata   = (nbytes == 1) ? i.rs2[7:0] * 32'h0101_0101 :
                (nbytes == 2) ? i.rs2[15:0] * 32'h0001_0001 : i.rs2;
    lane = i.rdata >> (8 * off);
    v    = i.rdata;
    if (i.f3 == LB || i.f3 == LBU) begin
      v = lane & 32'hFF;
      if (i.f3 == LB && v >= 32'd128) v = v - 32'd256;
    end else if (i.f3 == LH || i.f3 == LHU) begin
      v = lane & 32'hFFFF;
      if (i.f3 == LH && v >= 32'd32768) v = v - 32'd65536;
    end
    e.mem_data = v;
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t     i;
    logic [2:0] load_ops [5];
    logic [2:0] store_ops [3];
    int         kind;
    int         nbytes;
    logic [1:0] off;
    load_ops  = '{LB, LH, LW, LBU, LHU};
    store_ops = '{SB, SH, SW};
    kind  = $urandom_range(0, 2);
    i.alu = $urandom;
    i.rs2 = $urandom;
    i.pc  = $urandom & 32'hFFFF_FFFC;
    i.rdata = $urandom;
    i.rd  = 5'($urandom_range(1, 31));
    i.wait_cycles = 0;
    if (kind == 0) begin
      i.mw = 1'b0;
      i.rw = 1'($urandom_range(0, 1));
      i.wb = ($urandom_range(0, 1) == 0) ? WB_ALU_SEL : WB_PC4_SEL;
      i.f3 = 3'($urandom_range(0, 7));
    end else begin
      i.mw = (kind == 2);
      i.rw = (kind == 1);
      i.wb = (kind == 1) ? WB_MEM_SEL : WB_ALU_SEL;
      i.f3 = (kind == 1) ? load_ops[$urandom_range(0, 4)] : store_ops[$urandom_range(0, 2)];
      i.wait_cycles = $urandom_range(0, 3);
    end
    nbytes = (i.f3[1:0] == 2'b00) ? 1 : (i.f3[1:0] == 2'b01) ? 2 : 4;
    off    = 2'($urandom_range(0, 3));
    if (nbytes == 2) off[0] = 1'b0;
    if (nbytes == 4) off = 2'b00;
    i.alu[1:0] = off;
    return i;
  endfunction

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] rdata,
                                input logic [2:0] f3, input logic mw, input logic [1:0] wb,
                                input logic rw, input int wt);
    instr_t i;
    i.alu = alu; i.rs2 = rs2; i.rdata = rdata; i.f3 = f3; i.mw = mw; i.wb = wb;
    i.rw = rw; i.wait_cycles = wt; i.rd = 5'd7; i.pc = 32'h0000_0400;
    return i;
  endfunction

  task automatic set_nop();
    alu_result = 32'h0; rs2_data = 32'h0; pc = 32'h0; rd_addr = 5'h0;
    reg_write = 1'b0; mem_write = 1'b0; funct3 = 3'b000; wb_mux = WB_ALU_SEL;
    dmem_bus.ready = 1'b0; dmem_bus.rdata = 32'h0;
  endtask

  // Drives one instruction, plays memory with the chosen latency, then moves on.
  task automatic applyStimulus(input instr_t i);
    exp_t e;
    e = model(i);
    exp_q.push_back(e);
    alu_result = i.alu; rs2_data = i.rs2; pc = i.pc; rd_addr = i.rd;
    reg_write = i.rw; mem_write = i.mw; funct3 = i.f3; wb_mux = i.wb;
    if (!e.req) begin
      dmem_bus.ready = 1'($urandom_range(0, 1));
      dmem_bus.rdata = i.rdata;
    end else if (i.wait_cycles == 0) begin
      dmem_bus.ready = 1'b1;
      dmem_bus.rdata = i.rdata;
    end else begin
      dmem_bus.ready = 1'b0;
      dmem_bus.rdata = $urandom;
      repeat (i.wait_cycles) begin
        @(posedge clk);
        #2;
      end
      dmem_bus.ready = 1'b1;
      dmem_bus.rdata = i.rdata;
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: retire the previous cycle's accepted instruction, then check the live port.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (prev_accept) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("[TB] FAIL retire_without_expectation actual=accepted required=none");
        end else begin
          e = exp_q.pop_front();
          checkOutput("rd_addr_out", 32'(rd_addr_out), 32'(e.rd));
          checkOutput("reg_write_out", 32'(reg_write_out), 32'(e.rw));
          checkOutput("wb_mux_out", 32'(wb_mux_out), 32'(e.wb));
          checkOutput("alu_out_out", alu_out_out, e.alu);
          checkOutput("pc_out", pc_out, e.pc);
          checkOutput("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          if (e.is_load && !e.fault) checkOutput("mem_data_out", mem_data_out, e.mem_data);
`ifdef MEM_MISALIGN_TRAP_EN
          checkOutput("misalign_fault", 32'(misalign_fault), 32'(e.fault));
`endif
        end
        stall_cnt = 0;
      end else if (prev_bubble) begin
        checkOutput("bubble_reg_write", 32'(reg_write_out), 32'd0);
        checkOutput("bubble_wb_mux", 32'(wb_mux_out), 32'd0);
      end
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        checkOutput("forward_mem", forward_mem, e.alu);
        checkOutput("dmem_req", 32'(dmem_bus.req), 32'(e.req));
        if (e.req) begin
          checkOutput("dmem_addr", dmem_bus.addr, e.addr);
          checkOutput("dmem_we", 32'(dmem_bus.we), 32'(e.we));
          checkOutput("dmem_be", 32'(dmem_bus.be), 32'(e.be));
          if (e.we) checkOutput("dmem_wdata", dmem_bus.wdata, e.wdata);
        end
      end
      if (stall) stall_cnt++;
      if (stall_cnt > 20) begin
        chk_cnt++;
        err_cnt++;
        $display("[TB] FAIL stall_timeout actual=%0d required<=20", stall_cnt);
        stall_cnt = 0;
      end
      prev_accept = !stall;
      prev_bubble = stall;
    end
  end

  initial begin
    instr_t directed [$];
    reset = 1'b1;
    set_nop();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_reg_write_out", 32'(reg_write_out), 32'd0);
    checkOutput("reset_pc_out", pc_out, 32'd0);
    checkOutput("reset_alu_out", alu_out_out, 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_dmem_req", 32'(dmem_bus.req), 32'd0);

    directed.push_back(mk(32'h0000_0100, 32'hDEAD_BEEF, 32'h0, SW, 1'b1, WB_ALU_SEL, 1'b0, 0));
    directed.push_back(mk(32'h0000_0103, 32'h0000_00A5, 32'h0, SB, 1'b1, WB_ALU_SEL, 1'b0, 0));
    directed.push_back(mk(32'h0000_0101, 32'h0, 32'h0000_8000, LB, 1'b0, WB_MEM_SEL, 1'b1, 3));
    directed.push_back(mk(32'h0000_0102, 32'h0, 32'hBEEF_1234, LHU, 1'b0, WB_MEM_SEL, 1'b1, 1));
    directed.push_back(mk(32'h0000_0102, 32'h0, 32'hCAFE_F00D, LW, 1'b0, WB_MEM_SEL, 1'b1, 0));
    directed.push_back(mk(32'h0000_0055, 32'h0, 32'h0, SW, 1'b0, WB_ALU_SEL, 1'b1, 0));

    @(posedge clk);
    #2;
    mon_en = 1'b1;
    foreach (directed[k]) applyStimulus(directed[k]);
    for (int n = 0; n < 80; n++) applyStimulus(rand_instr());
    set_nop();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset arriving in WAIT together with ready must abandon the access.
    @(posedge clk);
    #2;
    alu_result = 32'h0000_0200; pc = 32'h0000_0800; rd_addr = 5'd9;
    reg_write = 1'b1; wb_mux = WB_MEM_SEL; funct3 = LW; dmem_bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("wait_state_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    dmem_bus.ready = 1'b1;
    dmem_bus.rdata = 32'h1234_5678;
    @(posedge clk);
    #2;
    reset = 1'b0;
    set_nop();
    @(negedge clk);
    checkOutput("rst_wait_dmem_req", 32'(dmem_bus.req), 32'd0);
    checkOutput("rst_wait_stall", 32'(stall), 32'd0);
    checkOutput("rst_wait_rd_addr_out", 32'(rd_addr_out), 32'd0);
    checkOutput("rst_wait_reg_write_out", 32'(reg_write_out), 32'd0);
    checkOutput("rst_wait_wb_mux_out", 32'(wb_mux_out), 32'd0);
    checkOutput("rst_wait_alu_out", alu_out_out, 32'd0);
    checkOutput("rst_wait_mem_data_out", mem_data_out, 32'd0);
    checkOutput("rst_wait_pc_out", pc_out, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    checkOutput("rst_wait_fault", 32'(misalign_fault), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
